md_issue_ctrl: RTL and testbench

- Issue/hazard controller sitting in the E stage between the pipeline and the multiply/divide unit.
- Decodes pipeline HI/LO requests (mult, multu, div, divu, mthi, mtlo, mfhi, mflo) and drives the unit's 4-bit op code and operands.
- Tracks operation latency with its own countdown and raises a combinational stall while the unit is occupied.
- Returns mfhi/mflo data to the pipeline once the result is valid.

---
 rtl/md_pkg.sv | 51 +++++
 rtl/md_issue_ctrl_lat_counter.sv | 33 +++
 rtl/md_issue_ctrl.sv | 107 ++++++++++
 tb/tb_md_issue_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide issue controller.
// Holds the request-kind encoding seen on the pipeline side, the op codes
// understood by the multiply/divide unit, default latencies, the controller
// state encoding and the kind-to-op mapping function.
package md_pkg;

    typedef enum logic [2:0] {
        K_MULT  = 3'd0,
        K_MULTU = 3'd1,
        K_DIV   = 3'd2,
        K_DIVU  = 3'd3,
        K_MTHI  = 3'd4,
        K_MTLO  = 3'd5,
        K_MFHI  = 3'd6,
        K_MFLO  = 3'd7
    } req_kind_e;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd3;
    localparam logic [3:0] MD_DIV   = 4'd4;
    localparam logic [3:0] MD_MULTU = 4'd8;
    localparam logic [3:0] MD_DIVU  = 4'd9;
    localparam logic [3:0] MD_MTHI  = 4'd10;
    localparam logic [3:0] MD_MTLO  = 4'd11;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;
    localparam int CNT_W_DEF    = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DIV_RUN = 2'd2
    } md_state_e;

    // MFHI/MFLO never reach the unit; they are served from md_hi/md_lo.
    function automatic logic [3:0] kind_to_op(input req_kind_e kind);
        logic [3:0] op;
        case (kind)
            K_MULT:  op = MD_MULT;
            K_MULTU: op = MD_MULTU;
            K_DIV:   op = MD_DIV;
            K_DIVU:  op = MD_DIVU;
            K_MTHI:  op = MD_MTHI;
            K_MTLO:  op = MD_MTLO;
            default: op = MD_NONE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/md_issue_ctrl_lat_counter.sv
// md_lat_counter: loadable countdown used to time multiply/divide occupancy.
// Ports:
//   clk, reset  - clock, synchronous active-high reset (clears the count)
//   load        - load load_val this edge (takes priority over decrement)
//   load_val    - value to load
//   en          - allow decrement while non-zero
//   cnt         - current count
//   zero        - cnt == 0
module md_lat_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: E-stage issue/hazard controller for the multiply/divide unit.
// Decodes HI/LO requests, issues op codes and operands to the unit, times the
// unit's occupancy with a local countdown, stalls the pipeline while the unit
// is occupied and returns mfhi/mflo data once it may be read.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   req_valid/kind/a/b   - E-stage HI/LO request and its rs/rt operands
//   flush                - cancels the current E-stage request
//   stall                - freeze F/D/E (combinational)
//   md_op, md_operand1/2 - op code and operands to the unit
//   md_hi, md_lo, md_busy- unit results and its own busy flag
//   rd_valid, rd_data    - mfhi/mflo result for the pipeline (combinational)
//   perf_stall_cnt       - count of stalled cycles (wraps)
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_kind,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        stall,
    output logic [3:0]  md_op,
    output logic [31:0] md_operand1,
    output logic [31:0] md_operand2,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    input  logic        md_busy,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic [31:0] perf_stall_cnt
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT);

    md_state_e        state;
    req_kind_e        kind;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;
    logic             busy_int;
    logic             req_live;
    logic             accept;
    logic             is_mul;
    logic             is_div;
    logic             is_mf;

    assign kind   = req_kind_e'(req_kind);
    assign is_mul = (kind == K_MULT) || (kind == K_MULTU);
    assign is_div = (kind == K_DIV)  || (kind == K_DIVU);
    assign is_mf  = (kind == K_MFHI) || (kind == K_MFLO);

    // Reset and flush both neutralise the request so every output is quiet.
    assign busy_int = !cnt_zero || md_busy;
    assign req_live = req_valid && !flush && !reset;
    assign stall    = req_live && busy_int;
    assign accept   = req_live && !busy_int;

    assign md_op       = accept ? kind_to_op(kind) : MD_NONE;
    assign md_operand1 = req_a;
    assign md_operand2 = req_b;

    assign rd_valid = accept && is_mf;
    assign rd_data  = !rd_valid        ? 32'd0 :
                      (kind == K_MFHI) ? md_hi : md_lo;

    md_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat (
        .clk      (clk),
        .reset    (reset),
        .load     (accept && (is_mul || is_div)),
        .load_val (is_div ? DIV_LOAD : MULT_LOAD),
        .en       (state != ST_IDLE),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    // Leaving a RUN state coincides with the count reaching zero; <= 1 also
    // covers a zero latency configuration.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else if (accept && is_mul) begin
            state <= ST_MUL_RUN;
        end else if (accept && is_div) begin
            state <= ST_DIV_RUN;
        end else if (state != ST_IDLE && cnt <= CNT_W'(1)) begin
            state <= ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt <= 32'd0;
        end else if (stall) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Testbench for md_issue_ctrl: directed scenarios followed by random traffic,
// checked cycle by cycle against a reference model that tracks the absolute
// cycle at which the unit becomes free and emulates HI/LO arithmetically.
module tb_md_issue_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_kind;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    logic        stall;
    logic [3:0]  md_op;
    logic [31:0] md_operand1;
    logic [31:0] md_operand2;
    logic [31:0] md_hi;
    logic [31:0] md_lo;
    logic        md_busy;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [31:0] perf_stall_cnt;

    md_issue_ctrl #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (5)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_kind       (req_kind),
        .req_a          (req_a),
        .req_b          (req_b),
        .flush          (flush),
        .stall          (stall),
        .md_op          (md_op),
        .md_operand1    (md_operand1),
        .md_operand2    (md_operand2),
        .md_hi          (md_hi),
        .md_lo          (md_lo),
        .md_busy        (md_busy),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .perf_stall_cnt (perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    longint      cyc = 0;
    longint      busy_until = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_perf = 32'd0;

    // Observations from the most recent step
    logic        o_stall;
    logic [3:0]  o_op;
    logic        o_rv;
    logic [31:0] o_rd;
    logic [31:0] o_perf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_op(input logic [2:0] k);
        logic [3:0] tbl [8];
        tbl = '{4'd3, 4'd8, 4'd4, 4'd9, 4'd10, 4'd11, 4'd0, 4'd0};
        return tbl[k];
    endfunction

    task automatic unit_exec(input logic [2:0] k, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic [63:0]        up;
        case (k)
            3'd0: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                m_hi = sp[63:32]; m_lo = sp[31:0];
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                m_hi = up[63:32]; m_lo = up[31:0];
            end
            3'd2: begin
                if (b == 32'd0) begin
                    m_hi = a; m_lo = 32'hFFFFFFFF;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    m_hi = 32'd0; m_lo = a;
                end else begin
                    m_lo = $signed(a) / $signed(b);
                    m_hi = $signed(a) % $signed(b);
                end
            end
            3'd3: begin
                if (b == 32'd0) begin
                    m_hi = a; m_lo = 32'hFFFFFFFF;
                end else begin
                    m_lo = a / b; m_hi = a % b;
                end
            end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic step(input logic v, input logic [2:0] k, input logic [31:0] a,
                        input logic [31:0] b, input logic f, input logic rst, input logic mb);
        logic        busy, live, acc, e_stall, e_rv;
        logic [3:0]  e_op;
        logic [31:0] e_rd;
        @(negedge clk);
        req_valid = v; req_kind = k; req_a = a; req_b = b;
        flush = f; reset = rst; md_busy = mb;
        md_hi = m_hi; md_lo = m_lo;
        busy    = (cyc < busy_until) || mb;
        live    = v && !f && !rst;
        e_stall = live && busy;
        acc     = live && !busy;
        e_op    = acc ? exp_op(k) : 4'd0;
        e_rv    = acc && (k == 3'd6 || k == 3'd7);
        e_rd    = !e_rv ? 32'd0 : (k == 3'd6 ? m_hi : m_lo);
        #1;
        o_stall = stall; o_op = md_op; o_rv = rd_valid; o_rd = rd_data; o_perf = perf_stall_cnt;
        chk("stall", {31'd0, stall}, {31'd0, e_stall});
        chk("md_op", {28'd0, md_op}, {28'd0, e_op});
        chk("rd_valid", {31'd0, rd_valid}, {31'd0, e_rv});
        chk("rd_data", rd_data, e_rd);
        chk("operand1", md_operand1, a);
        chk("operand2", md_operand2, b);
        chk("perf_stall_cnt", perf_stall_cnt, m_perf);
        @(posedge clk);
        if (rst) begin
            busy_until = cyc + 1;
            m_perf = 32'd0;
        end else begin
            if (e_stall) m_perf = m_perf + 32'd1;
            if (acc) begin
                if (k == 3'd0 || k == 3'd1) busy_until = cyc + 1 + MULT_LAT;
                if (k == 3'd2 || k == 3'd3) busy_until = cyc + 1 + DIV_LAT;
                unit_exec(k, a, b);
            end
        end
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    int ns;

    initial begin
        req_valid = 0; req_kind = 0; req_a = 0; req_b = 0;
        flush = 0; reset = 1; md_busy = 0; md_hi = 0; md_lo = 0;

        // Reset with a request pending: everything quiet
        step(1'b1, 3'd0, 32'd1, 32'd2, 1'b0, 1'b1, 1'b0);
        chk("rst_md_op", {28'd0, o_op}, 32'd0);
        step(1'b1, 3'd6, 32'd1, 32'd2, 1'b0, 1'b1, 1'b0);
        chk("rst_stall", {31'd0, o_stall}, 32'd0);
        idle();
        chk("rst_perf", o_perf, 32'd0);

        // mult 7 * -3, mfhi right behind it
        step(1'b1, 3'd0, 32'd7, 32'hFFFFFFFD, 1'b0, 1'b0, 1'b0);
        chk("mult_op", {28'd0, o_op}, 32'd3);
        ns = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 3'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
            ns += o_stall;
        end
        chk("mult_stalls", ns, 32'd5);
        chk("mfhi_mult", o_rd, 32'hFFFFFFFF);
        chk("perf_5", o_perf, 32'd5);
        step(1'b1, 3'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("mflo_mult", o_rd, 32'hFFFFFFEB);

        // divu 100 / 7, mflo immediately
        step(1'b1, 3'd3, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
        chk("divu_op", {28'd0, o_op}, 32'd9);
        ns = 0;
        for (int i = 0; i < 11; i++) begin
            step(1'b1, 3'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
            ns += o_stall;
        end
        chk("divu_stalls", ns, 32'd10);
        chk("mflo_divu", o_rd, 32'd14);
        step(1'b1, 3'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("mfhi_divu", o_rd, 32'd2);

        // mthi then mfhi: no stall
        step(1'b1, 3'd4, 32'h1234, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("mthi_op", {28'd0, o_op}, 32'd10);
        step(1'b1, 3'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("mthi_rv", {31'd0, o_rv}, 32'd1);
        chk("mthi_rd", o_rd, 32'h1234);

        // div interrupted by reset at T+3; mflo at T+4 goes straight through
        step(1'b1, 3'd2, 32'd50, 32'd5, 1'b0, 1'b0, 1'b0);
        idle();
        idle();
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 3'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_stall", {31'd0, o_stall}, 32'd0);
        chk("post_rst_rv", {31'd0, o_rv}, 32'd1);
        chk("post_rst_rd", o_rd, 32'd10);

        // flushed mult behind a running mult; countdown continues
        step(1'b1, 3'd1, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
        step(1'b1, 3'd0, 32'd9, 32'd9, 1'b1, 1'b0, 1'b0);
        chk("flush_stall", {31'd0, o_stall}, 32'd0);
        chk("flush_op", {28'd0, o_op}, 32'd0);
        ns = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 3'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
            ns += o_stall;
        end
        chk("flush_stalls", ns, 32'd4);
        chk("multu_lo", o_rd, 32'd12);

        // mult then div back to back
        step(1'b1, 3'd0, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
        ns = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 3'd2, 32'hFFFFFFF0, 32'd3, 1'b0, 1'b0, 1'b0);
            ns += o_stall;
        end
        chk("b2b_stalls", ns, 32'd5);
        chk("b2b_div_op", {28'd0, o_op}, 32'd4);
        ns = 0;
        for (int i = 0; i < 11; i++) begin
            step(1'b1, 3'd6, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
            ns += o_stall;
        end
        chk("b2b_div_busy", ns, 32'd10);
        chk("div_rem", o_rd, 32'hFFFFFFFF);

        // Random traffic, including divide by zero, flushes, resets, md_busy
        for (int i = 0; i < 500; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
            step($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), ra, rb,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 19) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
